// File: rtl/train_sequencer_pkg.sv
// Shared types for the training sequencer: fixed-point sample type, its
// constants, the sequencer state enum and a threshold-side helper.
package train_sequencer_pkg;

    // Signed Q8.8 fixed-point value used by the MLP datapath.
    typedef logic signed [15:0] sfp;

    localparam sfp ONE  = 16'sh0100;
    localparam sfp HALF = 16'sh0080;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        TEST  = 2'd2,
        DONE  = 2'd3
    } train_state_t;

    // True when a value lies strictly below the class-decision threshold.
    function automatic logic below(input sfp value, input sfp threshold);
        return value < threshold;
    endfunction

endpackage

// File: rtl/train_sequencer_class_match.sv
// class_match: combinational check that every model output lies on the same
// side of the decision threshold as its label (signed comparisons).
module class_match
    import train_sequencer_pkg::*;
#(
    parameter int NUM_OUTPUTS = 1,
    parameter sfp THRESHOLD   = HALF
) (
    input  sfp [NUM_OUTPUTS-1:0] prediction,
    input  sfp [NUM_OUTPUTS-1:0] expected,
    output logic                 match
);

    // Any output on the wrong side of the threshold makes the example wrong.
    always_comb begin
        match = 1'b1;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (below(prediction[k], THRESHOLD) != below(expected[k], THRESHOLD)) begin
                match = 1'b0;
            end else begin
                match = match;
            end
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// train_sequencer: steps a model through NUM_EPOCHS passes over the training
// split, then once over the test split, scoring each test example.
// Optional feature: define TRAIN_LR_DECAY_EN to halve the learning rate at
// every epoch boundary, floored at LR_MIN.
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int NUM_OUTPUTS = 1,
    parameter int NUM_TRAIN   = 600,
    parameter int NUM_TEST    = 400,
    parameter int NUM_EPOCHS  = 10,
    parameter int EXAMPLE_W   = 16,
    parameter sfp THRESHOLD   = HALF,
    parameter sfp LR_INIT     = ONE,
    parameter sfp LR_MIN      = sfp'(ONE >>> 6)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               req,
    input  logic                               ack,
    output logic [EXAMPLE_W-1:0]               example,
    output logic                               training,
    output sfp                                 learning_rate,
    input  sfp [NUM_OUTPUTS-1:0]               prediction,
    input  sfp [NUM_OUTPUTS-1:0]               expected,
    output logic [$clog2(NUM_EPOCHS+1)-1:0]    epoch,
    output logic [$clog2(NUM_TEST+1)-1:0]      correct,
    output logic                               busy,
    output logic                               done
);

    localparam int EPOCH_W   = $clog2(NUM_EPOCHS + 1);
    localparam int CORRECT_W = $clog2(NUM_TEST + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_TRAIN = TRAIN;
    localparam logic [1:0] ST_TEST  = TEST;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [EXAMPLE_W-1:0] LAST_TRAIN = EXAMPLE_W'(NUM_TRAIN - 1);
    localparam logic [EXAMPLE_W-1:0] FIRST_TEST = EXAMPLE_W'(NUM_TRAIN);
    localparam logic [EXAMPLE_W-1:0] LAST_TEST  = EXAMPLE_W'(NUM_TRAIN + NUM_TEST - 1);
    localparam logic [EPOCH_W-1:0]   LAST_EPOCH = EPOCH_W'(NUM_EPOCHS - 1);

`ifdef TRAIN_LR_DECAY_EN
    localparam logic DECAY_EN = 1'b1;
`else
    localparam logic DECAY_EN = 1'b0;
`endif

    logic [1:0]           state;
    logic [1:0]           state_nx;
    logic [EXAMPLE_W-1:0] example_nx;
    logic                 training_nx;
    sfp                   lr_nx;
    sfp                   lr_half;
    sfp                   lr_decayed;
    logic [EPOCH_W-1:0]   epoch_nx;
    logic [CORRECT_W-1:0] correct_nx;
    logic                 handshake;
    logic                 match;

    class_match #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .THRESHOLD   (THRESHOLD)
    ) u_class_match (
        .prediction (prediction),
        .expected   (expected),
        .match      (match)
    );

    // Next-state, counter and learning-rate decisions for the run.
    always_comb begin
        state_nx    = state;
        example_nx  = example;
        training_nx = training;
        lr_nx       = learning_rate;
        epoch_nx    = epoch;
        correct_nx  = correct;
        handshake   = req & ack;
        lr_half     = learning_rate >>> 1;
        lr_decayed  = (lr_half < LR_MIN) ? LR_MIN : lr_half;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx    = ST_TRAIN;
                    example_nx  = {EXAMPLE_W{1'b0}};
                    epoch_nx    = {EPOCH_W{1'b0}};
                    correct_nx  = {CORRECT_W{1'b0}};
                    training_nx = 1'b1;
                    lr_nx       = LR_INIT;
                end else begin
                    state_nx = state;
                end
            end
            ST_TRAIN: begin
                if (handshake) begin
                    if (example == LAST_TRAIN) begin
                        if (epoch == LAST_EPOCH) begin
                            // Last training example: move to the held-out split.
                            state_nx    = ST_TEST;
                            example_nx  = FIRST_TEST;
                            training_nx = 1'b0;
                        end else begin
                            example_nx = {EXAMPLE_W{1'b0}};
                            epoch_nx   = epoch + EPOCH_W'(1);
                            lr_nx      = DECAY_EN ? lr_decayed : learning_rate;
                        end
                    end else begin
                        example_nx = example + EXAMPLE_W'(1);
                    end
                end else begin
                    example_nx = example;
                end
            end
            ST_TEST: begin
                if (handshake) begin
                    if (match) begin
                        correct_nx = correct + CORRECT_W'(1);
                    end else begin
                        correct_nx = correct;
                    end
                    example_nx = example + EXAMPLE_W'(1);
                    if (example == LAST_TEST) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_TEST;
                    end
                end else begin
                    example_nx = example;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; status flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            req           <= 1'b0;
            example       <= {EXAMPLE_W{1'b0}};
            training      <= 1'b0;
            learning_rate <= LR_INIT;
            epoch         <= {EPOCH_W{1'b0}};
            correct       <= {CORRECT_W{1'b0}};
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            req           <= (state_nx == ST_TRAIN) || (state_nx == ST_TEST);
            example       <= example_nx;
            training      <= training_nx;
            learning_rate <= lr_nx;
            epoch         <= epoch_nx;
            correct       <= correct_nx;
            busy          <= (state_nx == ST_TRAIN) || (state_nx == ST_TEST);
            done          <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Scoreboard bench for train_sequencer: the driver pushes the expected
// per-handshake view of each run; a negedge monitor pops and compares.
module tb_train_sequencer;
    import train_sequencer_pkg::*;

    localparam int NO    = 2;
    localparam int NT    = 4;
    localparam int NS    = 2;
    localparam int NE    = 2;
    localparam int EW    = 8;
    localparam sfp THR   = HALF;
    localparam sfp LRI   = ONE;
    localparam sfp LRM   = sfp'(ONE >>> 2);
    localparam int TOTAL = NE * NT + NS;

    logic clk = 1'b0;
    logic rst, start, ack;
    logic req, training, busy, done;
    logic [EW-1:0] example;
    sfp learning_rate;
    sfp [NO-1:0] prediction, expected;
    logic [$clog2(NE+1)-1:0] epoch;
    logic [$clog2(NS+1)-1:0] correct;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { int ex; int tr; int ep; int lr; } exp_t;
    exp_t q[$];

    train_sequencer #(
        .NUM_OUTPUTS (NO), .NUM_TRAIN (NT), .NUM_TEST (NS), .NUM_EPOCHS (NE),
        .EXAMPLE_W (EW), .THRESHOLD (THR), .LR_INIT (LRI), .LR_MIN (LRM)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .req (req), .ack (ack),
        .example (example), .training (training), .learning_rate (learning_rate),
        .prediction (prediction), .expected (expected), .epoch (epoch),
        .correct (correct), .busy (busy), .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    // Learning rate for a given epoch: repeated halving, floored at LR_MIN.
    function automatic int lr_model(input int ep);
        int v;
        v = int'(LRI);
        for (int i = 0; i < ep; i++) begin
`ifdef TRAIN_LR_DECAY_EN
            v = (v / 2 < int'(LRM)) ? int'(LRM) : v / 2;
`endif
        end
        return v;
    endfunction

    // An example is right when each output and its label share a threshold side.
    function automatic int scored_right(input sfp [NO-1:0] p, input sfp [NO-1:0] l);
        sfp a, b;
        for (int k = 0; k < NO; k++) begin
            a = p[k];
            b = l[k];
            if ((a < THR) != (b < THR)) return 0;
        end
        return 1;
    endfunction

    function automatic sfp rand_sfp();
        case ($urandom_range(0, 4))
            0: return HALF;
            1: return HALF - 16'sd1;
            2: return ONE;
            3: return 16'sd0;
            default: return sfp'($urandom_range(0, 1023)) - 16'sd512;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_req"}, int'(req), 0);
        check({tag, "_example"}, int'(example), 0);
        check({tag, "_training"}, int'(training), 0);
        check({tag, "_lr"}, int'(learning_rate), int'(LRI));
        check({tag, "_epoch"}, int'(epoch), 0);
        check({tag, "_correct"}, int'(correct), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Monitor: every handshake seen by the DUT must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (req === 1'b1 && ack === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_handshake: example %0d, required no handshake", example);
            end else begin
                e = q.pop_front();
                check("hs_example", int'(example), e.ex);
                check("hs_training", int'(training), e.tr);
                check("hs_epoch", int'(epoch), e.ep);
                check("hs_lr", int'(learning_rate), e.lr);
            end
        end
    end

    // mode 0: ack=1, 1: random ack + start in TRAIN, 2: 3-cycle stall at example 2,
    // 3: reset mid-TEST, 4/5: directed scoring tables.
    task automatic do_run(input int mode);
        int n, cyc, exp_correct, stall, t, a;
        sfp [NO-1:0] p, l;
        exp_t e;
        n = 0; cyc = 0; exp_correct = 0; stall = 0;
        start = 1'b1;
        ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check("entry_req", int'(req), 1);
        check("entry_busy", int'(busy), 1);
        check("entry_done", int'(done), 0);
        check("entry_example", int'(example), 0);
        check("entry_epoch", int'(epoch), 0);
        check("entry_correct", int'(correct), 0);
        check("entry_training", int'(training), 1);
        check("entry_lr", int'(learning_rate), int'(LRI));
        while (n < TOTAL) begin
            if (mode == 3 && n == NE * NT + 1) begin
                ack = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset("async_reset");
                @(posedge clk); #1;
                rst = 1'b0;
                q.delete();
                return;
            end
            case (mode)
                0, 3, 4, 5: a = 1;
                2: begin
                    if (n == 2 && stall < 3) begin
                        a = 0;
                        stall++;
                        check("stall_example", int'(example), 2);
                        check("stall_req", int'(req), 1);
                    end else begin
                        a = 1;
                    end
                end
                default: a = ($urandom_range(0, 3) != 0) ? 1 : 0;
            endcase
            start = (mode == 1 && cyc == 3);
            for (int k = 0; k < NO; k++) begin
                p[k] = rand_sfp();
                l[k] = rand_sfp();
            end
            t = n - NE * NT;
            if (mode == 4 && t == 0) begin
                p[0] = 16'sd179; p[1] = 16'sd51;  l[0] = ONE; l[1] = 16'sd0;
            end else if (mode == 4 && t == 1) begin
                p[0] = 16'sd154; p[1] = 16'sd154; l[0] = ONE; l[1] = 16'sd0;
            end else if (mode == 5 && t == 0) begin
                p[0] = HALF; p[1] = 16'sd0; l[0] = 16'sd0; l[1] = 16'sd0;
            end else if (mode == 5 && t == 1) begin
                p[0] = HALF - 16'sd1; p[1] = 16'sd0; l[0] = 16'sd0; l[1] = 16'sd0;
            end
            prediction = p;
            expected = l;
            ack = 1'(a);
            if (a == 1) begin
                if (n < NE * NT) begin
                    e.ex = n % NT; e.tr = 1; e.ep = n / NT;
                end else begin
                    e.ex = NT + t; e.tr = 0; e.ep = NE - 1;
                    exp_correct += scored_right(p, l);
                end
                e.lr = lr_model(e.ep);
                q.push_back(e);
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        ack = 1'($urandom_range(0, 1));
        check("done_rise", int'(done), 1);
        if (mode == 0) check("run_cycles", cyc, TOTAL + 1);
        if (mode == 4 || mode == 5) check("scoring_directed", int'(correct), 1);
        check("final_correct", int'(correct), exp_correct);
        check("final_req", int'(req), 0);
        check("final_busy", int'(busy), 0);
        check("queue_drained", q.size(), 0);
        q.delete();
        ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold_correct", int'(correct), exp_correct);
        check("hold_done", int'(done), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0;
        prediction = '0; expected = '0;
        #1 check_reset("reset_t0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ack = 1'b1;
        @(posedge clk); #1;
        check_reset("idle_ack_ignored");
        do_run(0);
        do_run(4);
        do_run(5);
        do_run(2);
        do_run(3);
        check_reset("after_abort");
        do_run(0);
        for (int r = 0; r < 6; r++) do_run(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required run completion");
        $fatal(1, "watchdog");
    end

endmodule
